// File: rtl/pll_reset_cen_pkg.sv
// Shared types and default constants for the PLL reset / clock-enable block.
package pll_reset_cen_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLDOFF   = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int HOLDOFF_DEF     = 1024;
  localparam int DIV_96_TO_6     = 16;

endpackage

// File: rtl/pll_reset_cen_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared by async reset.
// Shared with other HPS-side inputs, so it carries no block-specific logic.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the input through the flop chain; the last stage is the clean output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_cen.sv
// PLL lock qualification, synchronous core reset and 6/3 MHz clock enables
// with a pause handshake aligned to 3 MHz boundaries.
//
// state     | meaning
// ----------+----------------------------------------------------------
// WAIT_LOCK | PLL not locked; core held in reset, enables off
// HOLDOFF   | lock seen; counting HOLDOFF_CYCLES of stable lock
// RUN       | core out of reset; divider and enables running
//
// Parameter minimums: SYNC_STAGES >= 2, HOLDOFF_CYCLES >= 2, DIV even and >= 4.
module pll_reset_cen
  import pll_reset_cen_pkg::*;
#(
  parameter int SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int HOLDOFF_CYCLES = HOLDOFF_DEF,
  parameter int DIV            = DIV_96_TO_6
) (
  input  logic clk,
  input  logic rst,
  input  logic locked,
  input  logic pause_req,
  output logic rst_out,
  output logic cen_6,
  output logic cen_6b,
  output logic cen_3,
  output logic cen_cpu,
  output logic pause_ack
);

  localparam int HW = (HOLDOFF_CYCLES > 2) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam int DW = $clog2(DIV);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_MID   = DW'(DIV / 2 - 1);

  logic          locked_s;
  state_t        state;
  state_t        next_state;
  logic [HW-1:0] hold_cnt;
  logic [DW-1:0] div_cnt;
  logic          phase;
  logic          run_next;
  logic          tick_6;
  logic          tick_6b;
  logic          tick_3;
  logic          ack_next;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
    .clk (clk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_LOCK;
    else     state <= next_state;
  end

  // Next-state decode: any loss of synchronized lock falls back to WAIT_LOCK
  always_comb begin
    next_state = state;
    unique case (state)
      WAIT_LOCK: if (locked_s) next_state = HOLDOFF;
      HOLDOFF: begin
        if (!locked_s)                 next_state = WAIT_LOCK;
        else if (hold_cnt == HOLD_LAST) next_state = RUN;
      end
      RUN:     if (!locked_s) next_state = WAIT_LOCK;
      default: next_state = WAIT_LOCK;
    endcase
  end

  // Output decode: enables and pause_ack are qualified by the next state so
  // that lock loss silences everything on the same edge that raises rst_out.
  always_comb begin
    run_next = (next_state == RUN);
    tick_6   = run_next && (div_cnt == DIV_LAST);
    tick_6b  = run_next && (div_cnt == DIV_MID);
    tick_3   = tick_6 && phase;
    ack_next = pause_ack;
    if (!run_next)   ack_next = 1'b0;
    else if (tick_3) ack_next = pause_req;
  end

  // Holdoff counter: restarts from zero whenever HOLDOFF is (re)entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                            hold_cnt <= '0;
    else if (state == HOLDOFF && next_state == HOLDOFF) hold_cnt <= hold_cnt + 1'b1;
    else                                                hold_cnt <= '0;
  end

  // Divider and 3 MHz phase bit: idle at zero until the cycle after reset releases
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      phase   <= 1'b0;
    end else begin
      if (state == RUN && run_next) div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      else                          div_cnt <= '0;
      if (!run_next)   phase <= 1'b0;
      else if (tick_6) phase <= ~phase;
    end
  end

  // Registered outputs; cen_cpu uses the pause_ack value loaded on this same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_out   <= 1'b1;
      cen_6     <= 1'b0;
      cen_6b    <= 1'b0;
      cen_3     <= 1'b0;
      cen_cpu   <= 1'b0;
      pause_ack <= 1'b0;
    end else begin
      rst_out   <= !run_next;
      cen_6     <= tick_6;
      cen_6b    <= tick_6b;
      cen_3     <= tick_3;
      cen_cpu   <= tick_6 && !ack_next;
      pause_ack <= ack_next;
    end
  end

endmodule

// File: tb/tb_pll_reset_cen.sv
// Directed testbench for pll_reset_cen with HOLDOFF_CYCLES=16, DIV=16.
module tb_pll_reset_cen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic locked = 1'b0;
  logic pause_req = 1'b0;
  logic rst_out, cen_6, cen_6b, cen_3, cen_cpu, pause_ack;

  int n_checks = 0;
  int n_pass   = 0;

  pll_reset_cen #(
    .SYNC_STAGES    (2),
    .HOLDOFF_CYCLES (16),
    .DIV            (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .locked    (locked),
    .pause_req (pause_req),
    .rst_out   (rst_out),
    .cen_6     (cen_6),
    .cen_6b    (cen_6b),
    .cen_3     (cen_3),
    .cen_cpu   (cen_cpu),
    .pause_ack (pause_ack)
  );

  always #5 clk = ~clk;

  // Steps n edges from the current point (edge 1 = next posedge) and records
  // the first edge at which each output shows its first active sample.
  task automatic run_edges(input int n, output int f_rst, output int f6b,
                           output int f6, output int f3, output int early);
    f_rst = -1; f6b = -1; f6 = -1; f3 = -1; early = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      if (f_rst < 0 && rst_out === 1'b0) f_rst = k;
      if (f6b < 0 && cen_6b === 1'b1) f6b = k;
      if (f6 < 0 && cen_6 === 1'b1) f6 = k;
      if (f3 < 0 && cen_3 === 1'b1) f3 = k;
      if (rst_out !== 1'b0 && {cen_6, cen_6b, cen_3, cen_cpu} !== 4'b0) early++;
    end
  endtask

  task automatic test_reset;
    int bad;
    rst = 1'b1; locked = 1'b0; pause_req = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rst_out !== 1'b1) $display("FAIL reset_rst_out: got %b want 1", rst_out);
    else n_pass++;
    n_checks++;
    if ({cen_6, cen_6b, cen_3, cen_cpu, pause_ack} !== 5'b0)
      $display("FAIL reset_outputs: got %b want 00000", {cen_6, cen_6b, cen_3, cen_cpu, pause_ack});
    else n_pass++;
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      if (rst_out !== 1'b1 || {cen_6, cen_6b, cen_3, cen_cpu, pause_ack} !== 5'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL no_lock_idle: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_lock_sequence;
    int f_rst, f6b, f6, f3, early;
    locked = 1'b1;
    run_edges(60, f_rst, f6b, f6, f3, early);
    n_checks++;
    if (f_rst != 19) $display("FAIL lock_rst_fall: got edge %0d want 19", f_rst);
    else n_pass++;
    n_checks++;
    if (f6b != 27) $display("FAIL lock_first_cen6b: got edge %0d want 27", f6b);
    else n_pass++;
    n_checks++;
    if (f6 != 35) $display("FAIL lock_first_cen6: got edge %0d want 35", f6);
    else n_pass++;
    n_checks++;
    if (f3 != 51) $display("FAIL lock_first_cen3: got edge %0d want 51", f3);
    else n_pass++;
    n_checks++;
    if (early != 0) $display("FAIL lock_enables_in_reset: got %0d want 0", early);
    else n_pass++;
  endtask

  task automatic test_steady_state;
    int n6, n6b, n3, lone3, badgap, last6;
    n6 = 0; n6b = 0; n3 = 0; lone3 = 0; badgap = 0; last6 = -1;
    for (int k = 0; k < 320; k++) begin
      @(posedge clk); #1;
      if (cen_6 === 1'b1) begin n6++; last6 = k; end
      if (cen_6b === 1'b1) begin
        n6b++;
        if (last6 >= 0 && k - last6 != 8) badgap++;
      end
      if (cen_3 === 1'b1) begin
        n3++;
        if (cen_6 !== 1'b1) lone3++;
      end
    end
    n_checks++;
    if (n6 != 20) $display("FAIL steady_cen6_count: got %0d want 20", n6);
    else n_pass++;
    n_checks++;
    if (n6b != 20) $display("FAIL steady_cen6b_count: got %0d want 20", n6b);
    else n_pass++;
    n_checks++;
    if (n3 != 10) $display("FAIL steady_cen3_count: got %0d want 10", n3);
    else n_pass++;
    n_checks++;
    if (lone3 != 0) $display("FAIL steady_cen3_align: got %0d want 0", lone3);
    else n_pass++;
    n_checks++;
    if (badgap != 0) $display("FAIL steady_cen6b_midway: got %0d want 0", badgap);
    else n_pass++;
  endtask

  task automatic test_pause;
    bit found;
    int ncpu, n6;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (cen_3 === 1'b1) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL pause_find_cen3: got none want cen_3 within 40 cycles");
    else n_pass++;
    ncpu = 0; n6 = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (cen_cpu === 1'b1) ncpu++;
      if (cen_6 === 1'b1) n6++;
      if (k == 5)  pause_req = 1'b1;
      if (k == 40) pause_req = 1'b0;
      if (k == 41) pause_req = 1'b1;
      if (k == 53) pause_req = 1'b0;
      if (k == 16) begin
        n_checks++;
        if ({cen_6, cen_cpu, pause_ack} !== 3'b110)
          $display("FAIL pause_before_tick: got %b want 110", {cen_6, cen_cpu, pause_ack});
        else n_pass++;
      end
      if (k == 32) begin
        n_checks++;
        if ({cen_6, cen_3, cen_cpu, pause_ack} !== 4'b1101)
          $display("FAIL pause_entry: got %b want 1101", {cen_6, cen_3, cen_cpu, pause_ack});
        else n_pass++;
      end
      if (k == 48) begin
        n_checks++;
        if ({cen_6, cen_cpu, pause_ack} !== 3'b101)
          $display("FAIL pause_held: got %b want 101", {cen_6, cen_cpu, pause_ack});
        else n_pass++;
      end
      if (k == 64) begin
        n_checks++;
        if ({cen_6, cen_3, cen_cpu, pause_ack} !== 4'b1110)
          $display("FAIL pause_exit: got %b want 1110", {cen_6, cen_3, cen_cpu, pause_ack});
        else n_pass++;
      end
    end
    n_checks++;
    if (ncpu != 2 || n6 != 4)
      $display("FAIL pause_counts: got cpu=%0d cen6=%0d want cpu=2 cen6=4", ncpu, n6);
    else n_pass++;
  endtask

  task automatic test_lock_loss;
    bit found;
    int bad, f_rst, f6b, f6, f3, early;
    pause_req = 1'b1;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk); #1;
      if (pause_ack === 1'b1) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL loss_pause_ack: got 0 want 1 within 40 cycles");
    else n_pass++;
    locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (rst_out !== 1'b0) $display("FAIL loss_latency_early: got %b want 0", rst_out);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({rst_out, cen_6, cen_6b, cen_3, cen_cpu, pause_ack} !== 6'b100000)
      $display("FAIL loss_edge3: got %b want 100000", {rst_out, cen_6, cen_6b, cen_3, cen_cpu, pause_ack});
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (rst_out !== 1'b1 || {cen_6, cen_6b, cen_3, cen_cpu, pause_ack} !== 5'b0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL loss_idle: got %0d bad cycles want 0", bad);
    else n_pass++;
    pause_req = 1'b0;
    locked = 1'b1;
    run_edges(60, f_rst, f6b, f6, f3, early);
    n_checks++;
    if (f_rst != 19 || f6 != 35 || f3 != 51)
      $display("FAIL loss_relock: got rst=%0d c6=%0d c3=%0d want 19 35 51", f_rst, f6, f3);
    else n_pass++;
  endtask

  task automatic test_holdoff_abort;
    int f_rst, f6b, f6, f3, early;
    rst = 1'b1; locked = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rst_out !== 1'b1) $display("FAIL abort_still_reset: got %b want 1", rst_out);
    else n_pass++;
    locked = 1'b0;
    @(posedge clk);
    @(negedge clk);
    locked = 1'b1;
    run_edges(40, f_rst, f6b, f6, f3, early);
    n_checks++;
    if (f_rst != 19) $display("FAIL abort_rst_fall: got edge %0d want 19", f_rst);
    else n_pass++;
  endtask

  task automatic test_async_reset;
    bit found;
    int f_rst, f6b, f6, f3, early;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(posedge clk); #1;
      if (cen_6 === 1'b1) found = 1;
    end
    n_checks++;
    if (!found) $display("FAIL async_find_cen6: got none want cen_6 within 20 cycles");
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({rst_out, cen_6, cen_6b, cen_3, cen_cpu, pause_ack} !== 6'b100000)
      $display("FAIL async_reset_now: got %b want 100000", {rst_out, cen_6, cen_6b, cen_3, cen_cpu, pause_ack});
    else n_pass++;
    #2 rst = 1'b0;
    run_edges(60, f_rst, f6b, f6, f3, early);
    n_checks++;
    if (f_rst != 19 || f6b != 27 || f6 != 35 || f3 != 51)
      $display("FAIL async_resequence: got rst=%0d c6b=%0d c6=%0d c3=%0d want 19 27 35 51",
               f_rst, f6b, f6, f3);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_steady_state();
    test_pause();
    test_lock_loss();
    test_async_reset();
    test_holdoff_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
